// File: rtl/sonar_stream_pkg.sv
// Shared types and helpers for the sonar sample stream.
// Channel index helpers work on an 8-bit mask padded with zeros.
package sonar_stream_pkg;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 24;
  localparam int CH_IDX_W = 3;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [NUM_CH-1:0] frame_t;

  // Lowest enabled channel >= from; bit 3 set means none left.
  function automatic logic [3:0] first_ch(
    input logic [7:0] m,
    input logic [3:0] from
  );
    logic [3:0] r;
    r = 4'h8;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = 4'(i);
    end
    return r;
  endfunction

  // True when no enabled channel sits above idx.
  function automatic logic is_top(
    input logic [7:0] m,
    input logic [2:0] idx
  );
    return ~|(m >> (4'(idx) + 4'd1));
  endfunction

endpackage

// File: rtl/frame_buf2.sv
// Two-entry frame FIFO holding parallel frames and their masks.
// Exposes head and the entry behind it for gapless frame switching.
module frame_buf2 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [NUM_CH*DATA_W-1:0] push_data,
  input  logic [NUM_CH-1:0]        push_mask,
  input  logic                     pop,
  output logic [1:0]               count,
  output logic [NUM_CH*DATA_W-1:0] head_data,
  output logic [NUM_CH*DATA_W-1:0] next_data,
  output logic [NUM_CH-1:0]        head_mask,
  output logic [NUM_CH-1:0]        next_mask
);

  localparam int FW = NUM_CH * DATA_W;

  logic [FW-1:0]     data_q [2];
  logic [NUM_CH-1:0] mask_q [2];
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        cnt_q;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= push_data;
        mask_q[wr_q] <= push_mask;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count     = cnt_q;
  assign head_data = data_q[rd_q];
  assign next_data = data_q[~rd_q];
  assign head_mask = mask_q[rd_q];
  assign next_mask = mask_q[~rd_q];

endmodule

// File: rtl/channel_serializer.sv
// Serializes buffered parallel frames into one sample per beat.
// Optional per-frame channel mask: define CHANNEL_MASK_EN.
module channel_serializer #(
  parameter int NUM_CH = sonar_stream_pkg::NUM_CH,
  parameter int DATA_W = sonar_stream_pkg::DATA_W
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arstn,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic signed [DATA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [sonar_stream_pkg::CH_IDX_W-1:0] m_axis_tuser,
  output logic                     m_axis_tlast
`ifdef CHANNEL_MASK_EN
  ,
  input  logic [NUM_CH-1:0]        ch_mask
`endif
);

  import sonar_stream_pkg::*;

  localparam int FW = NUM_CH * DATA_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  logic              rdy_q;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic [FW-1:0]     head_data;
  logic [FW-1:0]     next_data;
  logic [NUM_CH-1:0] in_mask;
  logic [NUM_CH-1:0] head_mask;
  logic [NUM_CH-1:0] next_mask;
  logic [7:0]        hm8;
  logic [7:0]        nm8;
  logic [3:0]        ch_first;
  logic [3:0]        ch_next;
  logic [3:0]        ch_nf;

`ifdef CHANNEL_MASK_EN
  assign in_mask = ch_mask;
`else
  assign in_mask = '1;
`endif

  function automatic logic [DATA_W-1:0] pick(
    input logic [FW-1:0] f,
    input logic [3:0]    idx
  );
    return f[int'(idx[2:0])*DATA_W +: DATA_W];
  endfunction

  assign s_axis_tready = rdy_q & (count != 2'd2);
  assign push = s_axis_tvalid & s_axis_tready;

  assign hm8 = 8'(head_mask);
  assign nm8 = 8'(next_mask);
  assign ch_first = first_ch(hm8, 4'd0);
  assign ch_next  = first_ch(hm8, {1'b0, m_axis_tuser} + 4'd1);
  assign ch_nf    = first_ch(nm8, 4'd0);

  // Empty-mask frames are dropped from IDLE; others leave on tlast.
  assign pop = ((state_q == IDLE) && (count != 2'd0) && (head_mask == '0))
             | ((state_q == SEND) && m_axis_tready && m_axis_tlast);

  frame_buf2 #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_arstn),
    .push     (push),
    .push_data(s_axis_tdata),
    .push_mask(in_mask),
    .pop      (pop),
    .count    (count),
    .head_data(head_data),
    .next_data(next_data),
    .head_mask(head_mask),
    .next_mask(next_mask)
  );

  // Input side opens one cycle after reset release.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) rdy_q <= 1'b0;
    else               rdy_q <= 1'b1;
  end

  // Beat sequencer with registered outputs.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      state_q       <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((count != 2'd0) && (head_mask != '0)) begin
            state_q       <= SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= $signed(pick(head_data, ch_first));
            m_axis_tuser  <= ch_first[2:0];
            m_axis_tlast  <= is_top(hm8, ch_first[2:0]);
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (!m_axis_tlast) begin
              m_axis_tdata <= $signed(pick(head_data, ch_next));
              m_axis_tuser <= ch_next[2:0];
              m_axis_tlast <= is_top(hm8, ch_next[2:0]);
            end else if ((count == 2'd2) && (next_mask != '0)) begin
              m_axis_tdata <= $signed(pick(next_data, ch_nf));
              m_axis_tuser <= ch_nf[2:0];
              m_axis_tlast <= is_top(nm8, ch_nf[2:0]);
            end else begin
              state_q       <= IDLE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_serializer.sv
// Self-checking bench for channel_serializer.
// Scoreboard expands each accepted frame into its expected beats.
module tb_channel_serializer;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 24;
  localparam int FW     = NUM_CH * DATA_W;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [FW-1:0]            s_tdata = '0;
  logic                     s_tvalid = 1'b0;
  logic                     s_tready;
  logic signed [DATA_W-1:0] m_tdata;
  logic                     m_tvalid;
  logic                     m_tready = 1'b0;
  logic [2:0]               m_tuser;
  logic                     m_tlast;
`ifdef CHANNEL_MASK_EN
  logic [NUM_CH-1:0]        ch_mask = '1;
`endif

  always #5 clk = ~clk;

  channel_serializer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .s_axis_aclk  (clk),
    .s_axis_arstn (rstn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast)
`ifdef CHANNEL_MASK_EN
    ,
    .ch_mask      (ch_mask)
`endif
  );

  typedef struct packed {
    logic [2:0]        ch;
    logic [DATA_W-1:0] d;
    logic              last;
  } beat_t;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [2:0]        user;
    logic [DATA_W-1:0] dout;
    logic              last;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    blocked = 0;
  int    beat_cnt = 0;
  bit    stall = 0;
  beat_t st;
  bit    stop_rand = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] cur_mask();
`ifdef CHANNEL_MASK_EN
    return ch_mask;
`else
    return '1;
`endif
  endfunction

  // Reference: every enabled channel in order, last on the highest one.
  task automatic model_push(input logic [FW-1:0] f,
                            input logic [NUM_CH-1:0] m);
    int top;
    beat_t b;
    top = -1;
    for (int k = 0; k < NUM_CH; k++) if (m[k]) top = k;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m[k]) begin
        b.ch   = 3'(k);
        b.d    = f[k*DATA_W +: DATA_W];
        b.last = (k == top);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_data", {8'd0, $unsigned(m_tdata)}, {8'd0, st.d});
        chk("stall_user", {29'd0, m_tuser}, {29'd0, st.ch});
        chk("stall_last", {31'd0, m_tlast}, {31'd0, st.last});
      end
      if (s_tvalid && s_tready) model_push(s_tdata, cur_mask());
      if (m_tvalid && m_tready) begin
        beat_t e;
        beat_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {29'd0, m_tuser}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {8'd0, $unsigned(m_tdata)}, {8'd0, e.d});
          chk("beat_user", {29'd0, m_tuser}, {29'd0, e.ch});
          chk("beat_last", {31'd0, m_tlast}, {31'd0, e.last});
        end
      end
      stall = m_tvalid && !m_tready;
      st.ch = m_tuser;
      st.d = $unsigned(m_tdata);
      st.last = m_tlast;
    end
  end

  function automatic logic [FW-1:0] mk_frame(input int tag);
    logic [FW-1:0] f;
    for (int k = 0; k < NUM_CH; k++)
      f[k*DATA_W +: DATA_W] = DATA_W'((tag << 8) | k);
    return f;
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_frame(input logic [FW-1:0] f);
    int n;
    s_tdata = f;
    s_tvalid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (s_tready) break;
      blocked++;
    end
    if (n == 500) chk("s_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int n;
    for (n = 0; n < lim; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    chk(nm, {31'd0, n < lim}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
    chk({nm, "_tlast"}, {31'd0, m_tlast}, 32'd0);
    chk({nm, "_tuser"}, {29'd0, m_tuser}, 32'd0);
    chk({nm, "_tdata"}, {8'd0, $unsigned(m_tdata)}, 32'd0);
    chk({nm, "_sready"}, {31'd0, s_tready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[NUM_CH];

  initial begin
    logic [FW-1:0] f;
    int run;
    int n;
    int b0;

    for (int i = 0; i < NUM_CH; i++) begin
      tbl[i].din  = DATA_W'(i + 1);
      tbl[i].user = 3'(i);
      tbl[i].dout = DATA_W'(i + 1);
      tbl[i].last = (i == NUM_CH - 1);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rstn = 1'b1;
    #1;
    chk("sready_at_release", {31'd0, s_tready}, 32'd0);
    @(negedge clk);
    chk("sready_after_release", {31'd0, s_tready}, 32'd1);
    @(posedge clk);
    #1;

    // Single frame 1..8, full-rate sink, table-driven beats
    m_tready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) f[i*DATA_W +: DATA_W] = tbl[i].din;
    send_frame(f);
    @(negedge clk);
    chk("latency_n", {31'd0, m_tvalid}, 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      @(negedge clk);
      chk("tbl_valid", {31'd0, m_tvalid}, 32'd1);
      chk("tbl_user", {29'd0, m_tuser}, {29'd0, tbl[i].user});
      chk("tbl_data", {8'd0, $unsigned(m_tdata)}, {8'd0, tbl[i].dout});
      chk("tbl_last", {31'd0, m_tlast}, {31'd0, tbl[i].last});
    end
    @(negedge clk);
    chk("idle_after_frame", {31'd0, m_tvalid}, 32'd0);
    @(posedge clk);
    #1;

    // Three frames back to back
    blocked = 0;
    run = 0;
    fork
      begin
        for (int fi = 0; fi < 3; fi++) send_frame(mk_frame(16 + fi));
      end
      begin
        for (n = 0; n < 50; n++) begin
          @(negedge clk);
          if (m_tvalid) break;
        end
        while (m_tvalid && run < 100) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_sready_drop", {31'd0, blocked > 0}, 32'd1);
    chk("b2b_contiguous", run, 32'd24);
    wait_drain("b2b_drain", 100);

    // Random backpressure, 30% sink duty
    stop_rand = 0;
    fork
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 99) < 30);
        end
      end
    join_none
    for (int fi = 0; fi < 20; fi++) begin
      for (int k = 0; k < NUM_CH; k++)
        f[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      if (fi % 3 == 0) begin
        f[0 +: DATA_W] = 24'h800000;
        f[(NUM_CH-1)*DATA_W +: DATA_W] = 24'h7FFFFF;
      end
`ifdef CHANNEL_MASK_EN
      ch_mask = NUM_CH'($urandom);
`endif
      send_frame(f);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain("rand_drain", 3000);
    stop_rand = 1;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
`ifdef CHANNEL_MASK_EN
    ch_mask = '1;
`endif

    // Reset at beat 3 of a frame
    send_frame(mk_frame(48));
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_tvalid && m_tuser == 3'd3) break;
    end
    chk("reach_beat3", {31'd0, n < 50}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(mk_frame(64));
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_tvalid) break;
    end
    chk("post_rst_user", {29'd0, m_tuser}, 32'd0);
    chk("post_rst_data", {8'd0, $unsigned(m_tdata)}, 32'h004000);
    wait_drain("post_rst_drain", 100);

`ifdef CHANNEL_MASK_EN
    // Sparse mask and empty mask
    ch_mask = 8'b0010_0101;
    b0 = beat_cnt;
    send_frame(mk_frame(80));
    wait_drain("mask_drain", 100);
    chk("mask_beats", beat_cnt - b0, 32'd3);
    ch_mask = '0;
    b0 = beat_cnt;
    send_frame(mk_frame(96));
    repeat (20) @(negedge clk);
    chk("zero_mask_beats", beat_cnt - b0, 32'd0);
    chk("zero_mask_sready", {31'd0, s_tready}, 32'd1);
    @(posedge clk);
    #1;
    ch_mask = '1;
`else
    b0 = 0;
`endif

    chk("final_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_serializer.md
CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning the number of channels per frame (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 24, meaning the signed sample width.
REQ-003 SHALL have port s_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port s_axis_arstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_tdata, input, NUM_CH*DATA_W bits: parallel frame, channel k in bits [k*DATA_W +: DATA_W].
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: frame valid.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: frame accepted when tvalid & tready.
REQ-008 SHALL have port m_axis_tdata, output, DATA_W bits, signed: serialized sample.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have port m_axis_tuser, output, 3 bits: channel index of the current beat.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: marks the last emitted channel of a frame.
REQ-013 SHALL have port ch_mask, input, NUM_CH bits: per-channel enable, present only under CHANNEL_MASK_EN.

Function
REQ-014 SHALL buffer up to 2 accepted frames in FIFO order.
REQ-015 SHALL drive s_axis_tready = (buffered frames < 2); it has no combinational dependence on m_axis_tready.
REQ-016 SHALL, on a frame accepted at edge N into an empty buffer, assert m_axis_tvalid after edge N+1 with channel 0 (first enabled channel).
REQ-017 SHALL emit channels in ascending index order; m_axis_tuser = channel index, zero-extended.
REQ-018 SHALL assert m_axis_tlast only on the highest enabled channel of a frame.
REQ-019 SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while m_axis_tvalid & !m_axis_tready.
REQ-020 SHALL advance one channel per m handshake; after the tlast handshake, SHALL pop the frame and present the next buffered frame's first beat on the following cycle with no idle cycle.
REQ-021 SHALL, on a simultaneous s-side push and m-side pop in the same cycle, perform both and keep the count unchanged.
REQ-022 SHALL implement the state machine IDLE (buffer empty, m_axis_tvalid=0) -> SEND (frame present) -> IDLE (last beat taken, buffer empty) or SEND (next frame).
REQ-023 SHALL never drop, duplicate or reorder samples under arbitrary backpressure on either side.

Reset
REQ-024 SHALL, while s_axis_arstn=0, force m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0, an empty buffer, and the state IDLE.
REQ-025 SHALL, on reset mid-frame, discard all buffered data; after release, the first beat SHALL be channel 0 of a newly accepted frame.
REQ-026 SHALL raise s_axis_tready one cycle after reset deassertion.

Configuration
REQ-027 SHALL, with CHANNEL_MASK_EN defined, sample ch_mask at frame acceptance, store it with the frame, and skip disabled channels; REQ-018 applies to the highest enabled index.
REQ-028 SHALL, with CHANNEL_MASK_EN defined, accept a frame whose stored mask is all-zero and discard it with no output beat.
REQ-029 SHALL, without CHANNEL_MASK_EN, omit the ch_mask port and emit all NUM_CH channels of every frame.

Structure
REQ-030 SHALL take NUM_CH, DATA_W, CH_IDX_W=3, typedef sample_t (signed DATA_W) and typedef frame_t (NUM_CH sample_t array) from shared package sonar_stream_pkg.
REQ-031 SHALL place the 2-entry frame buffer in sub-module frame_buf2 (push/pop/count; frame and mask storage).

Verification
REQ-032 SHALL cover a single frame {0x000001..0x000008} with m_axis_tready=1 -> 8 beats on consecutive cycles, tuser 0..7, tlast only on tuser 7, data in matching order.
REQ-033 SHALL cover 3 back-to-back frames with m_axis_tready=1 -> s_axis_tready drops after 2 accepts, 24 contiguous beats with no bubbles, FIFO order preserved.
REQ-034 SHALL cover random m_axis_tready at 30% duty -> output stable during stalls and the scoreboard matches all samples (e.g. 0x800000, 0x7FFFFF intact).
REQ-035 SHALL cover s_axis_arstn low at beat 3 of a frame -> all outputs 0 immediately; after release the next frame starts at tuser 0.
REQ-036 SHALL cover, under CHANNEL_MASK_EN, ch_mask=8'b0010_0101 -> beats tuser 0,2,5 with tlast on 5; and ch_mask=0 -> frame accepted with no beats.
